// File: rtl/colour_sense_ctrl.sv
// colour_sense_ctrl
//
// Runs colour_sensor measurements at a patch node. Collects NSAMP fresh
// results per round, majority-votes them into one debounced colour and hands
// the result to the message module over a valid/ack handshake. A watchdog
// bounds every measurement, so a stalled sensor ends in an error result
// instead of hanging the path controller.
//
// Parameters
//   NSAMP      results collected per vote round (1..7)
//   MAJ        minimum identical results needed to accept a colour (1..NSAMP)
//   MAX_ROUNDS vote rounds tried before reporting no consensus (1..3)
//   TIMEOUT    clk cycles allowed per measurement (21-bit watchdog)
//
// Ports
//   clk          system clock, all state updates on its rising edge
//   reset        synchronous, active-high, overrides everything
//   start        one-cycle request from the path controller
//   color_in     sensor result: 000 white, 001 red, 010 green, 011 blue
//   color_valid  sensor result valid
//   measure      registered one-cycle restart pulse to the sensor
//   color_out    voted colour, 000 on error
//   out_valid    color_out/err valid, held until out_ack
//   out_ack      consumer accepted the result
//   err          qualified by out_valid: timeout or no consensus
//   busy         high in every state except idle

module colour_sense_ctrl #(
  parameter int unsigned NSAMP      = 3,
  parameter int unsigned MAJ        = 2,
  parameter int unsigned MAX_ROUNDS = 2,
  parameter int unsigned TIMEOUT    = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] color_in,
  input  logic       color_valid,
  output logic       measure,
  output logic [2:0] color_out,
  output logic       out_valid,
  input  logic       out_ack,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitLo,
    StWaitHi,
    StVote,
    StOut
  } state_e;

  localparam logic [2:0]  LastIdx   = 3'(NSAMP - 1);
  localparam logic [1:0]  LastRound = 2'(MAX_ROUNDS - 1);
  localparam logic [20:0] WdLimit   = 21'(TIMEOUT - 1);
  localparam logic [2:0]  MajThr    = 3'(MAJ);

  localparam logic [2:0] ColWhite = 3'b000;
  localparam logic [2:0] ColRed   = 3'b001;
  localparam logic [2:0] ColGreen = 3'b010;
  localparam logic [2:0] ColBlue  = 3'b011;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  round_q, round_d;
  logic [20:0] wd_q, wd_d;
  // One tally per colour, indexed by the two-bit colour code (0 = white).
  logic [2:0]  tally_q [4];
  logic [2:0]  tally_d [4];
  logic [2:0]  color_q, color_d;
  logic        err_q, err_d;
  logic        measure_q, out_valid_q, busy_q;

  // Out-of-range sensor codes (1xx) are counted as white.
  logic [1:0]  slot;
  logic        wd_expired;
  logic        win_found;
  logic [2:0]  win_color;

  assign slot       = color_in[2] ? 2'd0 : color_in[1:0];
  assign wd_expired = (wd_q == WdLimit);

  // Priority scan: red, green, blue, then white.
  always_comb begin
    win_found = 1'b0;
    win_color = ColWhite;
    if (tally_q[1] >= MajThr) begin
      win_found = 1'b1;
      win_color = ColRed;
    end else if (tally_q[2] >= MajThr) begin
      win_found = 1'b1;
      win_color = ColGreen;
    end else if (tally_q[3] >= MajThr) begin
      win_found = 1'b1;
      win_color = ColBlue;
    end else if (tally_q[0] >= MajThr) begin
      win_found = 1'b1;
      win_color = ColWhite;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    round_d = round_q;
    wd_d    = wd_q;
    tally_d = tally_q;
    color_d = color_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        // A color_valid seen here is left over from an earlier measurement.
        if (start) begin
          state_d = StTrig;
          idx_d   = 3'd0;
          round_d = 2'd0;
          for (int i = 0; i < 4; i++) begin
            tally_d[i] = 3'd0;
          end
        end
      end

      StTrig: begin
        wd_d    = 21'd0;
        state_d = StWaitLo;
      end

      StWaitLo: begin
        // Valid must drop first, proving the sensor restarted.
        if (wd_expired) begin
          color_d = ColWhite;
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          wd_d = wd_q + 21'd1;
          if (!color_valid) begin
            state_d = StWaitHi;
          end
        end
      end

      StWaitHi: begin
        if (wd_expired) begin
          color_d = ColWhite;
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          wd_d = wd_q + 21'd1;
          if (color_valid) begin
            if (tally_q[slot] != 3'd7) begin
              tally_d[slot] = tally_q[slot] + 3'd1;
            end
            if (idx_q == LastIdx) begin
              state_d = StVote;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = StTrig;
            end
          end
        end
      end

      StVote: begin
        if (win_found) begin
          color_d = win_color;
          err_d   = 1'b0;
          state_d = StOut;
        end else if (round_q < LastRound) begin
          round_d = round_q + 2'd1;
          idx_d   = 3'd0;
          for (int i = 0; i < 4; i++) begin
            tally_d[i] = 3'd0;
          end
          state_d = StTrig;
        end else begin
          color_d = ColWhite;
          err_d   = 1'b1;
          state_d = StOut;
        end
      end

      StOut: begin
        // Ack in the very first OUT cycle is accepted as well.
        if (out_ack) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs. Outputs are derived from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      round_q     <= 2'd0;
      wd_q        <= 21'd0;
      for (int i = 0; i < 4; i++) begin
        tally_q[i] <= 3'd0;
      end
      color_q     <= ColWhite;
      err_q       <= 1'b0;
      measure_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      round_q     <= round_d;
      wd_q        <= wd_d;
      for (int i = 0; i < 4; i++) begin
        tally_q[i] <= tally_d[i];
      end
      color_q     <= color_d;
      err_q       <= err_d;
      measure_q   <= (state_d == StTrig);
      out_valid_q <= (state_d == StOut);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign measure   = measure_q;
  assign color_out = color_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_colour_sense_ctrl.sv
// Self-checking bench for colour_sense_ctrl. Two instances share the sensor
// model: inst A uses NSAMP=3, inst B uses NSAMP=4, both MAJ=2, MAX_ROUNDS=2,
// TIMEOUT=100. Expected results come from a counting model of the vote rules.

module tb_colour_sense_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [2:0] color_in;
  logic       color_valid;
  logic       out_ack;

  logic       measure_a, out_valid_a, err_a, busy_a;
  logic       measure_b, out_valid_b, err_b, busy_b;
  logic [2:0] color_out_a, color_out_b;

  logic       sel;  // 0 selects inst A, 1 selects inst B
  logic       measure_s, out_valid_s, err_s, busy_s;
  logic [2:0] color_s;

  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  bit         stall = 1'b0;
  int         dly_lo = 1;
  int         dly_hi = 6;
  logic [2:0] stim [0:15];
  logic [2:0] samp_q [$];
  logic [2:0] sens_c;
  int         sens_d;

  always #5 clk = ~clk;

  colour_sense_ctrl #(
    .NSAMP(3), .MAJ(2), .MAX_ROUNDS(2), .TIMEOUT(100)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .color_in(color_in),
    .color_valid(color_valid), .measure(measure_a), .color_out(color_out_a),
    .out_valid(out_valid_a), .out_ack(out_ack), .err(err_a), .busy(busy_a)
  );

  colour_sense_ctrl #(
    .NSAMP(4), .MAJ(2), .MAX_ROUNDS(2), .TIMEOUT(100)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .color_in(color_in),
    .color_valid(color_valid), .measure(measure_b), .color_out(color_out_b),
    .out_valid(out_valid_b), .out_ack(out_ack), .err(err_b), .busy(busy_b)
  );

  assign measure_s   = sel ? measure_b   : measure_a;
  assign out_valid_s = sel ? out_valid_b : out_valid_a;
  assign err_s       = sel ? err_b       : err_a;
  assign busy_s      = sel ? busy_b      : busy_a;
  assign color_s     = sel ? color_out_b : color_out_a;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Vote model: count each round, first colour in red/green/blue/white order
  // reaching maj wins; otherwise retry until rounds are used up.
  function automatic void model(input int nsamp, input int maj, input int rounds,
                                output logic e, output logic [2:0] c, output int np);
    int cnt [4];
    int pri [4] = '{1, 2, 3, 0};
    e  = 1'b1;
    c  = 3'b000;
    np = rounds * nsamp;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int i = 0; i < nsamp; i++) begin
        logic [2:0] s;
        s = stim[r * nsamp + i];
        if (s[2]) cnt[0]++;
        else cnt[s[1:0]]++;
      end
      for (int k = 0; k < 4; k++) begin
        if (cnt[pri[k]] >= maj) begin
          e  = 1'b0;
          c  = 3'(pri[k]);
          np = (r + 1) * nsamp;
          return;
        end
      end
    end
  endfunction

  // Sensor model: on measure, valid drops one cycle later, then rises with the
  // next queued colour after a random delay. In stall mode valid stays high.
  initial begin
    color_valid = 1'b1;
    color_in    = 3'b000;
    forever begin
      @(posedge clk); #1;
      if (stall) color_valid = 1'b1;
      if (measure_s) begin
        pulses++;
        if (!stall) begin
          if (samp_q.size() > 0) sens_c = samp_q.pop_front();
          else sens_c = 3'b000;
          sens_d = $urandom_range(dly_hi, dly_lo);
          @(posedge clk); #1;
          check("measure_one_cycle", int'(measure_s), 0);
          color_valid = 1'b0;
          repeat (sens_d) @(posedge clk);
          #1;
          color_in    = sens_c;
          color_valid = 1'b1;
        end
      end
    end
  end

  // mode 0: normal ack after random hold, 1: extra start while busy,
  // 2: ack held high from the start (accepted in first OUT cycle)
  task automatic run_txn(input string tag, input bit use_b, input int mode);
    logic       e;
    logic [2:0] c;
    int         np, cyc, hold, nsamp;
    nsamp = use_b ? 4 : 3;
    model(nsamp, 2, 2, e, c, np);
    sel = use_b;
    samp_q.delete();
    for (int i = 0; i < nsamp * 2; i++) samp_q.push_back(stim[i]);
    pulses = 0;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (mode == 2) out_ack = 1'b1;
    check({tag, "_busy"}, int'(busy_s), 1);
    cyc = 0;
    while (!out_valid_s && cyc < 3000) begin
      if (mode == 1 && cyc == 7) begin
        if (use_b) start_b = 1'b1;
        else start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
    end
    check({tag, "_valid"}, int'(out_valid_s), 1);
    check({tag, "_color"}, int'(color_s), int'(c));
    check({tag, "_err"}, int'(err_s), int'(e));
    check({tag, "_pulses"}, pulses, np);
    if (mode != 2) begin
      hold = $urandom_range(3, 0);
      repeat (hold) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, int'(out_valid_s), 1);
        check({tag, "_hold_color"}, int'(color_s), int'(c));
      end
      out_ack = 1'b1;
    end
    @(posedge clk); #1;
    out_ack = 1'b0;
    check({tag, "_ack_valid"}, int'(out_valid_s), 0);
    check({tag, "_ack_busy"}, int'(busy_s), 0);
    if (mode == 1) begin
      repeat (15) @(posedge clk);
      #1;
      check({tag, "_no_second"}, int'(out_valid_s), 0);
      check({tag, "_idle_busy"}, int'(busy_s), 0);
      check({tag, "_no_extra_pulse"}, pulses, np);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, p;
    logic [2:0] base;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    out_ack = 1'b0;
    sel     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_measure", int'(measure_a), 0);
    check("rst_color", int'(color_out_a), 0);
    check("rst_valid", int'(out_valid_a), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Consistent red
    stim[0] = 3'b001; stim[1] = 3'b001; stim[2] = 3'b001;
    run_txn("red", 1'b0, 0);
    // Split vote
    stim[0] = 3'b011; stim[1] = 3'b010; stim[2] = 3'b011;
    run_txn("split", 1'b0, 0);
    // No consensus in either round
    stim[0] = 3'b001; stim[1] = 3'b010; stim[2] = 3'b011;
    stim[3] = 3'b001; stim[4] = 3'b010; stim[5] = 3'b011;
    run_txn("nocons", 1'b0, 0);
    // Priority tie on the four-sample instance
    stim[0] = 3'b010; stim[1] = 3'b011; stim[2] = 3'b011; stim[3] = 3'b010;
    run_txn("tie", 1'b1, 0);
    // Out-of-range codes count as white
    stim[0] = 3'b110; stim[1] = 3'b011; stim[2] = 3'b000;
    run_txn("white_1xx", 1'b0, 0);
    // Start while busy is ignored
    stim[0] = 3'b011; stim[1] = 3'b011; stim[2] = 3'b001;
    run_txn("spam", 1'b0, 1);
    // Ack already high when out_valid rises
    stim[0] = 3'b010; stim[1] = 3'b010; stim[2] = 3'b010;
    run_txn("early_ack", 1'b0, 2);

    // Sensor stall: valid never drops
    sel    = 1'b0;
    stall  = 1'b1;
    pulses = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("stall_measure", int'(measure_s), 1);
    n = 0;
    while (!out_valid_s && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_cycles", n, 101);
    check("stall_color", int'(color_s), 0);
    check("stall_err", int'(err_s), 1);
    check("stall_pulses", pulses, 1);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    stall   = 1'b0;
    check("stall_ack_valid", int'(out_valid_s), 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset while waiting for the sensor result
    dly_lo = 6;
    dly_hi = 6;
    stim[0] = 3'b001; stim[1] = 3'b001; stim[2] = 3'b001;
    samp_q.delete();
    for (int i = 0; i < 3; i++) samp_q.push_back(stim[i]);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (color_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("rstmid_busy_before", int'(busy_s), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_measure", int'(measure_s), 0);
    check("rstmid_valid", int'(out_valid_s), 0);
    check("rstmid_busy", int'(busy_s), 0);
    check("rstmid_color", int'(color_s), 0);
    check("rstmid_err", int'(err_s), 0);
    reset = 1'b0;
    p = pulses;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_no_pulse", pulses, p);
    check("rstmid_idle", int'(busy_s), 0);
    dly_lo = 1;
    dly_hi = 6;

    // Randomized rounds on both instances
    for (int t = 0; t < 12; t++) begin
      base = 3'($urandom_range(7, 0));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(1, 0) == 1) stim[i] = base;
        else stim[i] = 3'($urandom_range(7, 0));
      end
      run_txn("rand", t[0], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/colour_sense_ctrl.md
Name: colour_sense_ctrl

Overview:
- Sequences `colour_sensor` measurements when the bot reaches a patch node.
- Takes NSAMP consecutive fresh results and majority-votes them into one debounced colour.
- Presents the colour to the message module with a valid/ack handshake.
- Adds a per-measurement watchdog so a stalled sensor cannot hang the path controller.

Parameters:
- NSAMP, 3: results collected per vote round (1..7).
- MAJ, 2: minimum identical results needed to accept a colour (1..NSAMP).
- MAX_ROUNDS, 2: vote rounds attempted before declaring no-consensus (1..3).
- TIMEOUT, 2000000: clk cycles allowed per single measurement (40 ms at 50 MHz); 21-bit counter.

Ports:
- clk  input  1  50 MHz system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request from the path controller at a patch node.
- color_in  input  3  result from `colour_sensor` (000 white, 001 red, 010 green, 011 blue).
- color_valid  input  1  `colour_sensor` valid.
- measure  output  1  restart pulse to `colour_sensor`.
- color_out  output  3  voted colour.
- out_valid  output  1  color_out/err are valid.
- out_ack  input  1  consumer accepted the result.
- err  output  1  qualified by out_valid: 1 = timeout or no consensus.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset:
  - One clock, `clk`; every register updates on posedge clk.
  - `reset` is synchronous, active-high, and highest priority, including mid-operation.
  - Reset values: state=IDLE, measure=0, color_out=000, out_valid=0, err=0, busy=0; all counters and tallies cleared.
- IDLE:
  - busy=0.
  - start=1 -> TRIG; sample index, round counter and the four 3-bit tallies are cleared.
  - A color_valid present in IDLE is stale and is ignored.
- TRIG:
  - measure=1 for exactly one cycle; watchdog cleared.
  - -> WAIT_LO.
- WAIT_LO:
  - Wait for color_valid=0, which confirms the sensor left DONE. The sensor drops valid 2 cycles after measure.
  - Then -> WAIT_HI.
- WAIT_HI:
  - Wait for color_valid=1, then capture color_in into the tally for that value.
  - color_in values 1xx are tallied as white.
  - If sample index = NSAMP-1 -> VOTE; otherwise increment the index and -> TRIG.
- Watchdog:
  - Runs in WAIT_LO and WAIT_HI.
  - When it reaches TIMEOUT-1 -> OUT with err=1, color_out=000.
- VOTE (one cycle):
  - Scan tallies in priority order red, green, blue, white.
  - The first tally >= MAJ wins -> OUT with err=0 and color_out = winner.
  - With no winner:
    - If round < MAX_ROUNDS-1: increment round, clear tallies and index, -> TRIG.
    - Otherwise -> OUT with err=1, color_out=000.
- OUT:
  - out_valid=1; color_out and err are held stable until out_ack=1.
  - out_ack sampled high -> out_valid=0 on the next edge, -> IDLE.
  - out_ack arriving in the same cycle out_valid first rises counts as accepted.
- Other rules:
  - start while busy=1 is ignored (not queued).
  - out_ack outside OUT is ignored.
  - measure is registered and never high for more than one cycle per TRIG.
  - Tallies saturate at 7; they cannot overflow given NSAMP<=7.
- Latency:
  - Nominal, no timeout: roughly NSAMP × (sensor measurement + 4) cycles.
  - OUT is entered the cycle after the last sample (VOTE adds 1 cycle).

Test Plan:
- Consistent red:
  - Stimulus: sensor model returns 001 for all 3 samples; start pulse.
  - Response: exactly 3 measure pulses; out_valid with color_out=001, err=0.
  - After out_ack: out_valid=0 next cycle and busy=0.
- Split vote:
  - Stimulus: samples 011, 010, 011.
  - Response: color_out=011, err=0.
- Priority tie:
  - Stimulus: NSAMP=4, MAJ=2, samples 010, 011, 011, 010.
  - Response: green wins by priority -> color_out=010.
- No consensus:
  - Stimulus: samples 001, 010, 011 in both rounds.
  - Response: 6 measure pulses, then color_out=000, err=1.
- Sensor stall:
  - Stimulus: TIMEOUT=100; color_valid held 1 after measure.
  - Response: err=1, color_out=000 exactly 100 cycles after entering WAIT_LO.
- Busy/reset handling:
  - Stimulus: start pulse mid-measurement.
  - Response: ignored; one result only.
  - Stimulus: reset asserted in WAIT_HI.
  - Response: all outputs reach reset values at the next edge; no further measure pulse.
